// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared types and helpers for the store read-modify-write engine.
//   store_type_e : store width encoding (SB/SH/SW/SD) as carried on req_type
//   rmw_state_e  : sequencing states of store_rmw_unit
//   DW_BYTES     : bytes per memory doubleword
//   is_aligned() : natural-alignment check for a store width and byte offset
// -----------------------------------------------------------------------------
package store_pkg;

  localparam int DW_BYTES = 8;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2,
    ST_SD = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } rmw_state_e;

  // A store is aligned when its offset is a multiple of its size.
  function automatic logic is_aligned(input store_type_e st, input logic [2:0] off);
    logic ok;
    case (st)
      ST_SB:   ok = 1'b1;
      ST_SH:   ok = (off[0] == 1'b0);
      ST_SW:   ok = (off[1:0] == 2'b00);
      ST_SD:   ok = (off == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Combinational byte-lane merge of a right-justified store into a doubleword.
// Ports:
//   old_dw    in  64  doubleword read from memory
//   new_dw    in  64  store data, right-justified
//   st_type   in  2   store width (store_type_e)
//   offset    in  3   byte offset of the store inside the doubleword
//   merged_dw out 64  old_dw with the store's lanes replaced
// -----------------------------------------------------------------------------
module store_lane_merge
  import store_pkg::*;
(
  input  logic [63:0]  old_dw,
  input  logic [63:0]  new_dw,
  input  store_type_e  st_type,
  input  logic [2:0]   offset,
  output logic [63:0]  merged_dw
);

  localparam int DW_W = DW_BYTES * 8;

  logic [DW_W-1:0] size_mask_s;
  logic [DW_W-1:0] lane_mask_s;
  logic [DW_W-1:0] shifted_s;
  logic [5:0]      shamt_s;

  // Byte-granular mask covering the store's width, before positioning.
  always_comb begin
    case (st_type)
      ST_SB:   size_mask_s = 64'h0000_0000_0000_00FF;
      ST_SH:   size_mask_s = 64'h0000_0000_0000_FFFF;
      ST_SW:   size_mask_s = 64'h0000_0000_FFFF_FFFF;
      ST_SD:   size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
      default: size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // Bits of new_dw above the store width are discarded by the mask, so the
  // caller need not zero them.
  assign shamt_s     = {offset, 3'b000};
  assign lane_mask_s = size_mask_s << shamt_s;
  assign shifted_s   = new_dw << shamt_s;
  assign merged_dw   = (old_dw & ~lane_mask_s) | (shifted_s & lane_mask_s);

endmodule

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
// Sequential read-modify-write engine: reads the aligned doubleword enclosing
// a store, merges the store bytes into their lanes and writes it back. One
// store in flight; misaligned stores are accepted and rejected with a pulse.
// Configuration macro: STORE_SD_BYPASS_EN -- when defined, an aligned SD skips
// the read and writes req_data directly.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   store request handshake (ready only in IDLE)
//   req_addr/data/type    store byte address, right-justified data, width
//   mem_rd_en/addr        one-cycle read strobe and aligned read address
//   mem_rd_data/valid     read return (only sampled while waiting)
//   mem_wr_en/addr/data   write request held until mem_wr_ack
//   mem_wr_ack            write accepted (only sampled while writing)
//   done                  one-cycle pulse when a store completes
//   misaligned            one-cycle pulse when a store is rejected
// -----------------------------------------------------------------------------
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  logic [1:0]        req_type,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [63:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              done,
  output logic              misaligned
);

  rmw_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [63:0]       data_r;
  store_type_e       type_r;
  logic [63:0]       merged_s;
  store_type_e       req_type_s;
  logic [ADDR_W-1:0] req_dw_addr_s;

  assign req_type_s    = store_type_e'(req_type);
  assign req_dw_addr_s = {req_addr[ADDR_W-1:3], 3'b000};

  store_lane_merge u_merge (
    .old_dw    (mem_rd_data),
    .new_dw    (data_r),
    .st_type   (type_r),
    .offset    (addr_r[2:0]),
    .merged_dw (merged_s)
  );

  // Store sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      addr_r      <= '0;
      data_r      <= 64'h0;
      type_r      <= ST_SB;
      req_ready   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= 64'h0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      mem_rd_en  <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            if (is_aligned(req_type_s, req_addr[2:0])) begin
              addr_r <= req_addr;
              data_r <= req_data;
              type_r <= req_type_s;
`ifdef STORE_SD_BYPASS_EN
              if (req_type_s == ST_SD) begin
                // Full-doubleword store: nothing to preserve, skip the read.
                state_r     <= S_WRITE;
                req_ready   <= 1'b0;
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= req_dw_addr_s;
                mem_wr_data <= req_data;
              end else begin
                state_r     <= S_READ;
                req_ready   <= 1'b0;
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= req_dw_addr_s;
              end
`else
              state_r     <= S_READ;
              req_ready   <= 1'b0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= req_dw_addr_s;
`endif
            end else begin
              // Rejected store: stay ready, touch no memory.
              misaligned <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            state_r     <= S_WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= {addr_r[ADDR_W-1:3], 3'b000};
            mem_wr_data <= merged_s;
          end
        end
        S_WRITE: begin
          if (mem_wr_ack) begin
            state_r   <= S_IDLE;
            mem_wr_en <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mem_wr_en <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// -----------------------------------------------------------------------------
// tb_store_rmw_unit
// Self-checking bench for store_rmw_unit. Expected writes are computed by a
// byte-wise reference merge at issue time and queued; they are popped and
// compared when the unit presents its write. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_type;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        done;
  logic        misaligned;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [63:0] mem   [logic [63:0]];
  logic [63:0] model [logic [63:0]];
  int          errors = 0;
  int          checks = 0;

  store_rmw_unit #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_merge(input logic [63:0] old_dw, input logic [63:0] nd,
                                              input logic [1:0] typ, input int off);
    logic [63:0] r;
    int n;
    r = old_dw;
    n = 1 << int'(typ);
    for (int b = 0; b < n; b++) r[8*(off+b) +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] dw_of(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  // Drive a request at the current falling edge and queue its expected write.
  task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [1:0] t);
    logic [63:0] exp_dw;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    exp_dw    = model_merge(model[dw_of(a)], d, t, int'(a[2:0]));
    model[dw_of(a)] = exp_dw;
    sb_q.push_back('{addr: dw_of(a), data: exp_dw});
  endtask

  // Sequence one RMW from T+1 to T+4; returns at the falling edge of T+4.
  task automatic serve(input int ack_wait);
    wr_t e;
    logic [63:0] ra;
    @(negedge clk);  // T+1
    req_valid = 1'b0;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL rd_en_t1: got %b want 1", mem_rd_en); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_busy: got %b want 0", req_ready); end
    ra = mem_rd_addr;
    checks++;
    if (sb_q.size() == 0 || ra !== sb_q[0].addr) begin
      errors++; $display("FAIL rd_addr: got %h want %h", ra, (sb_q.size() != 0) ? sb_q[0].addr : 64'h0);
    end
    @(negedge clk);  // T+2
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL rd_en_pulse: got %b want 0", mem_rd_en); end
    mem_rd_valid = 1'b1;
    mem_rd_data  = mem.exists(ra) ? mem[ra] : 64'h0;
    @(negedge clk);  // T+3
    mem_rd_valid = 1'b0;
    mem_rd_data  = 64'h0;
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en_t3: got %b want 1", mem_wr_en); end
    if (sb_q.size() == 0) begin
      errors++; checks++; $display("FAIL sb_empty: got 0 entries want 1");
      e = '{addr: 64'h0, data: 64'h0};
    end else begin
      e = sb_q.pop_front();
    end
    checks++; if (mem_wr_addr !== e.addr) begin errors++; $display("FAIL wr_addr: got %h want %h", mem_wr_addr, e.addr); end
    checks++; if (mem_wr_data !== e.data) begin errors++; $display("FAIL wr_data: got %h want %h", mem_wr_data, e.data); end
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== e.addr || mem_wr_data !== e.data || done !== 1'b0) begin
        errors++; $display("FAIL wr_hold: got en=%b a=%h d=%h done=%b want en=1 a=%h d=%h done=0",
                           mem_wr_en, mem_wr_addr, mem_wr_data, done, e.addr, e.data);
      end
    end
    mem_wr_ack = 1'b1;
    mem[mem_wr_addr] = mem_wr_data;
    @(negedge clk);  // T+4 (+ack_wait)
    mem_wr_ack = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_t4: got %b want 1", done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_t4: got %b want 1", req_ready); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_drop: got %b want 0", mem_wr_en); end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_rd_addr !== 64'h0 || mem_wr_en !== 1'b0 ||
        mem_wr_addr !== 64'h0 || mem_wr_data !== 64'h0 || done !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy=%b rd=%b ra=%h wr=%b wa=%h wd=%h done=%b mis=%b want rdy=1, rest 0",
               tag, req_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, done, misaligned);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = 64'h0; req_data = 64'h0; req_type = 2'd0;
    mem_rd_data = 64'h0; mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_sb();
    mem[64'h1000] = 64'h1122_3344_5566_7788; model[64'h1000] = 64'h1122_3344_5566_7788;
    issue(64'h1005, 64'h0000_0000_0000_00AB, 2'd0);
    serve(0);
    checks++; if (mem[64'h1000] !== 64'h1122_AB44_5566_7788) begin errors++; $display("FAIL sb_image: got %h want %h", mem[64'h1000], 64'h1122_AB44_5566_7788); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_sw_hold();
    mem[64'h2000] = 64'hFFFF_FFFF_FFFF_FFFF; model[64'h2000] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(64'h2004, 64'h0000_0000_DEAD_BEEF, 2'd2);
    serve(3);
    checks++; if (mem[64'h2000] !== 64'hDEAD_BEEF_FFFF_FFFF) begin errors++; $display("FAIL sw_image: got %h want %h", mem[64'h2000], 64'hDEAD_BEEF_FFFF_FFFF); end
    @(negedge clk);
  endtask

  task automatic test_sh_aligned();
    mem[64'h3000] = 64'h0102_0304_0506_0708; model[64'h3000] = 64'h0102_0304_0506_0708;
    issue(64'h3002, 64'hFFFF_FFFF_FFFF_BEEF, 2'd1);
    serve(1);
    checks++; if (mem[64'h3000] !== 64'h0102_0304_BEEF_0708) begin errors++; $display("FAIL sh_image: got %h want %h", mem[64'h3000], 64'h0102_0304_BEEF_0708); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int seen_mem;
    seen_mem = 0;
    req_valid = 1'b1; req_addr = 64'h3003; req_data = 64'h1234; req_type = 2'd1;
    @(negedge clk);  // T+1: pulse, still ready; issue a second bad store
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_t1: got %b want 1", misaligned); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", req_ready); end
    if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) seen_mem++;
    req_addr = 64'h2002; req_type = 2'd2;
    @(negedge clk);
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_second: got %b want 1", misaligned); end
    if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) seen_mem++;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misaligned); end
    for (int i = 0; i < 3; i++) begin
      if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || req_ready !== 1'b1) seen_mem++;
      @(negedge clk);
    end
    checks++; if (seen_mem != 0) begin errors++; $display("FAIL mis_no_mem: got %0d bad cycles want 0", seen_mem); end
  endtask

  task automatic test_sd();
    wr_t e;
    mem[64'h4000] = 64'hAAAA_AAAA_AAAA_AAAA; model[64'h4000] = 64'hAAAA_AAAA_AAAA_AAAA;
    issue(64'h4000, 64'h0123_4567_89AB_CDEF, 2'd3);
`ifdef STORE_SD_BYPASS_EN
    @(negedge clk);  // T+1: write, no read
    req_valid = 1'b0;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL sd_no_read: got %b want 0", mem_rd_en); end
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL sd_wr_t1: got %b want 1", mem_wr_en); end
    e = sb_q.pop_front();
    checks++; if (mem_wr_addr !== e.addr || mem_wr_data !== e.data) begin errors++; $display("FAIL sd_wr: got %h/%h want %h/%h", mem_wr_addr, mem_wr_data, e.addr, e.data); end
    mem_wr_ack = 1'b1;
    mem[mem_wr_addr] = mem_wr_data;
    @(negedge clk);  // T+2
    mem_wr_ack = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sd_done_t2: got %b want 1", done); end
`else
    e = '{addr: 64'h0, data: 64'h0};
    serve(0);
`endif
    checks++; if (mem[64'h4000] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sd_image: got %h want %h", mem[64'h4000], 64'h0123_4567_89AB_CDEF); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int bad;
    bad = 0;
    mem[64'h1000] = 64'h0; model[64'h1000] = 64'h0;
    issue(64'h1005, 64'h77, 2'd0);
    @(negedge clk);  // T+1
    req_valid = 1'b0;
    @(negedge clk);  // T+2, waiting for read data
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    sb_q.delete();
    model[64'h1000] = 64'h0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_wr_en !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    mem[64'h10] = 64'h0; model[64'h10] = 64'h0;
    issue(64'h10, 64'h5A, 2'd0);
    serve(0);
    issue(64'h11, 64'hC3, 2'd0);  // same cycle as the first done
    serve(0);
    checks++; if (mem[64'h10] !== 64'h0000_0000_0000_C35A) begin errors++; $display("FAIL b2b_image: got %h want %h", mem[64'h10], 64'h0000_0000_0000_C35A); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sw_hold();
    test_sh_aligned();
    test_misaligned();
    test_sd();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Sequential read-modify-write engine between the execute-stage store request and the 64-bit data memory. Each accepted store is sequenced through the following steps:
- read the enclosing aligned doubleword;
- merge the store's bytes into the correct lanes;
- write the doubleword back.

Misaligned stores are rejected with a one-cycle pulse. Only one store is in flight at a time.

## Interface
- ADDR_W, 64, byte-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  store byte address
- req_data  in  64  store data, right-justified (byte in [7:0], half in [15:0], word in [31:0])
- req_type  in  2  0=SB, 1=SH, 2=SW, 3=SD
- mem_rd_en  out  1  one-cycle read strobe
- mem_rd_addr  out  ADDR_W  req_addr with bits [2:0] cleared
- mem_rd_data  in  64  read doubleword
- mem_rd_valid  in  1  mem_rd_data valid
- mem_wr_en  out  1  write request, held until ack
- mem_wr_addr  out  ADDR_W  aligned doubleword address
- mem_wr_data  out  64  merged doubleword
- mem_wr_ack  in  1  write accepted this cycle
- done  out  1  one-cycle pulse, store completed
- misaligned  out  1  one-cycle pulse, store rejected

## Operation
- FSM states: IDLE, READ, WAIT, WRITE.
- IDLE → READ: on req_valid && req_ready, when the store is aligned. Latch addr, data and type.
- Alignment: SB is always aligned; SH requires addr[0]=0; SW requires addr[1:0]=0; SD requires addr[2:0]=0.
- Misaligned request: accepted, then misaligned pulses the next cycle. The FSM stays in IDLE and no memory access is made.
- READ: mem_rd_en=1 for exactly one cycle, then go to WAIT.
- WAIT: when mem_rd_valid=1, register the merged data and go to WRITE. Otherwise wait indefinitely.
- Merge: off = addr[2:0]; size = 1/2/4/8 bytes. Bytes off..off+size-1 of the old doubleword are replaced by bytes 0..size-1 of req_data. All other bytes are preserved bit-exact.
- WRITE: mem_wr_en=1 with stable addr and data until mem_wr_ack. On ack, go to IDLE and pulse done the next cycle.
- mem_rd_valid is ignored outside WAIT. mem_wr_ack is ignored outside WRITE.

## Timing
- Reset values: req_ready=1; every other output is 0; state=IDLE; latched registers are 0.
- An rst_n assertion mid-operation aborts immediately. Any pending read or write is abandoned, and no done pulse is issued for it.
- Request accepted at cycle T:
  - mem_rd_en at T+1.
  - Earliest usable mem_rd_valid is T+2.
  - Earliest mem_wr_en is T+3.
  - With ack at T+3, done and req_ready are both high at T+4.
- Back-to-back stores: the next acceptance can occur in the same cycle done is high.
- Misaligned request accepted at T: misaligned=1 at T+1 and req_ready stays 1. A second request can therefore be accepted at T+1.
- mem_wr_addr and mem_wr_data change only on entry to WRITE.

## Configuration
- STORE_SD_BYPASS_EN defined: an aligned SD skips READ and WAIT. The unit goes IDLE → WRITE with mem_wr_data=req_data, giving mem_wr_en at T+1 and done at T+2 with immediate ack.
- STORE_SD_BYPASS_EN undefined: SD performs the full read-modify-write. The result is identical, and the latency is the same as for other store types.

## Structure
- Package store_pkg holds:
  - the store_type_e enum (SB/SH/SW/SD);
  - the rmw_state_e enum;
  - the DW_BYTES=8 constant;
  - an alignment-check function.
- Sub-module store_lane_merge: purely combinational. Inputs are the old doubleword, new data, type and offset; the output is the merged doubleword. It is instantiated once inside store_rmw_unit.

## Test plan
- SB at addr 0x1005 with data 0xAB, memory word 0x1122334455667788: read at 0x1000, write 0x1122AB4455667788, done at T+4 with zero-wait memory.
- SW at 0x2004 with data 0xDEADBEEF, old data 0xFFFFFFFFFFFFFFFF: write 0xDEADBEEFFFFFFFFF. mem_wr_en must stay high for 3 cycles of withheld ack, with stable data.
- SH at 0x3003: misaligned pulses at T+1; no mem_rd_en or mem_wr_en ever asserts; req_ready stays 1.
- SD at 0x4000 with data 0x0123456789ABCDEF:
  - with STORE_SD_BYPASS_EN, write at T+1 and no read;
  - without it, read at T+1 and write 0x0123456789ABCDEF.
- rst_n pulled low in WAIT while mem_rd_valid is low: all outputs return to reset values asynchronously; a later mem_rd_valid is ignored; no done pulse.
- Two back-to-back SB stores, to 0x10 and 0x11: the second is accepted in the same cycle as the first done; both bytes are present in the final memory image.
